uart_tx_fifo: RTL and testbench

- Byte buffer and sequencer directly upstream of the UART transmitter.
- Accepts bytes from producer logic (command parser, string ROM, etc.) at any rate up to one per clock and stores them in a circular FIFO.
- Feeds bytes to the transmitter one at a time over its valid/byte/done handshake.
- Lets producers fire-and-forget multi-byte messages without tracking serial timing.

---
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and transmit sequencer sitting in front of a UART transmitter.
// Producers push bytes at up to one per clock; bytes leave one at a time over a valid/done handshake.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_byte,
  output logic                  wr_ready,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  tx_valid,
  output logic [7:0]            tx_byte,
  input  logic                  tx_done
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    WAIT_CLEAR
  } state_t;

  logic [7:0]            mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  overflow_q, overflow_d;

  logic                  full;
  logic                  push;
  logic                  pop;

  // Both full and pop look only at the registered count, so a same-cycle pop never frees room for a push.
  always_comb begin
    full       = (count_q == FULL_CNT);
    push       = wr_valid && !full;
    pop        = (state_q == IDLE) && (count_q != '0);

    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    overflow_d = wr_valid && full;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d    = count_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(pop);

    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_byte_d  = mem[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + 1'b1;
          tx_valid_d = 1'b1;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) state_d = WAIT_CLEAR;
      end
      WAIT_CLEAR: begin
        // Wait for done to drop so a wide done pulse cannot be mistaken for the next byte's completion.
        if (!tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr_q] <= wr_byte;
  end

  assign wr_ready = !full;
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_valid = tx_valid_q;
  assign tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table vectors, directed corner sequences and random traffic
// checked every cycle against a queue-based reference model and a behavioural transmitter.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int BIT_CLKS = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       wr_ready;
  logic       overflow;
  logic [4:0] count;
  logic       empty;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_byte  (wr_byte),
    .wr_ready (wr_ready),
    .overflow (overflow),
    .count    (count),
    .empty    (empty),
    .tx_valid (tx_valid),
    .tx_byte  (tx_byte),
    .tx_done  (tx_done)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: stored bytes as a queue, link is busy from a send until done has risen and fallen.
  logic [7:0] m_q[$];
  bit         m_busy    = 1'b0;
  bit         m_done_hi = 1'b0;
  bit         m_valid   = 1'b0;
  bit         m_ovf     = 1'b0;
  logic [7:0] m_byte    = 8'h00;

  // Transmitter: 10 bits of BIT_CLKS clocks, then done high for 2 clocks; hold stalls before done.
  int xm_cnt    = 0;
  int done_left = 0;
  bit xm_hold   = 1'b0;

  typedef struct {
    bit         drain;
    bit         v;
    logic [7:0] b;
    bit         rst;
    int         e_count;
    bit         e_valid;
    logic [7:0] e_byte;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit rst, input bit done);
    bit full_now;
    bit pop_now;
    if (rst) begin
      m_q.delete();
      m_busy    = 1'b0;
      m_done_hi = 1'b0;
      m_valid   = 1'b0;
      m_ovf     = 1'b0;
      m_byte    = 8'h00;
      return;
    end
    full_now = (m_q.size() == DEPTH);
    pop_now  = !m_busy && (m_q.size() != 0);
    m_valid  = pop_now;
    m_ovf    = v && full_now;
    if (pop_now) begin
      m_byte    = m_q.pop_front();
      m_busy    = 1'b1;
      m_done_hi = 1'b0;
    end else if (m_busy) begin
      if (!m_done_hi) begin
        if (done) m_done_hi = 1'b1;
      end else if (!done) begin
        m_busy = 1'b0;
      end
    end
    if (v && !full_now) m_q.push_back(b);
  endtask

  task automatic xmit_step();
    if (tx_valid) begin
      xm_cnt = BIT_CLKS * 10;
    end else if (xm_cnt > 0 && !(xm_hold && xm_cnt == 1)) begin
      xm_cnt--;
      if (xm_cnt == 0) done_left = 2;
    end else if (done_left > 0) begin
      done_left--;
    end
    tx_done = (done_left > 0);
  endtask

  task automatic cycle(input bit v, input logic [7:0] b, input bit rst);
    bit done_applied;
    wr_valid     = v;
    wr_byte      = b;
    reset        = rst;
    done_applied = tx_done;
    @(posedge clock);
    #1;
    model_step(v, b, rst, done_applied);
    chk("count",    count,    m_q.size());
    chk("empty",    empty,    m_q.size() == 0);
    chk("wr_ready", wr_ready, m_q.size() < DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("tx_valid", tx_valid, m_valid);
    chk("tx_byte",  tx_byte,  m_byte);
    xmit_step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_q.size() != 0 || m_busy) && n < budget) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: actual=%0d cycles required<%0d", n, budget);
    end
  endtask

  task automatic wait_xmit_idle(input int budget);
    int n = 0;
    while ((xm_cnt != 0 || done_left != 0) && n < budget) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL xmit_idle_timeout: actual=%0d cycles required<%0d", n, budget);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrote;
    int n;

    tbl[0] = '{drain:0, v:0, b:8'h00, rst:1, e_count:0, e_valid:0, e_byte:8'h00};
    tbl[1] = '{drain:0, v:1, b:8'hA5, rst:0, e_count:1, e_valid:0, e_byte:8'h00};
    tbl[2] = '{drain:0, v:0, b:8'h00, rst:0, e_count:0, e_valid:1, e_byte:8'hA5};
    tbl[3] = '{drain:0, v:0, b:8'h00, rst:0, e_count:0, e_valid:0, e_byte:8'hA5};
    tbl[4] = '{drain:1, v:1, b:8'h48, rst:0, e_count:1, e_valid:0, e_byte:8'hA5};
    tbl[5] = '{drain:0, v:1, b:8'h69, rst:0, e_count:1, e_valid:1, e_byte:8'h48};
    tbl[6] = '{drain:0, v:1, b:8'h0A, rst:0, e_count:2, e_valid:0, e_byte:8'h48};
    tbl[7] = '{drain:0, v:0, b:8'h00, rst:0, e_count:2, e_valid:0, e_byte:8'h48};

    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].drain) drain(2000);
      cycle(tbl[i].v, tbl[i].b, tbl[i].rst);
      chk($sformatf("tbl%0d_count", i),    count,    tbl[i].e_count);
      chk($sformatf("tbl%0d_tx_valid", i), tx_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_tx_byte", i),  tx_byte,  tbl[i].e_byte);
    end
    drain(2000);

    // Full FIFO with the sequencer parked waiting for done.
    xm_hold = 1'b1;
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      if (i == 15) begin
        chk("full_count",    count,    16);
        chk("full_wr_ready", wr_ready, 0);
      end
    end
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count,    16);
    cycle(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", overflow, 0);
    xm_hold = 1'b0;
    drain(4000);

    // Push on the exact cycle the idle sequencer pops, with five bytes queued.
    xm_hold = 1'b1;
    cycle(1'b1, 8'hE0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0);
    chk("pp_count_before", count, 5);
    xm_hold = 1'b0;
    n = 0;
    while (!(!m_busy && m_q.size() != 0) && n < 500) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    cycle(1'b1, 8'h77, 1'b0);
    chk("pp_count",    count,    5);
    chk("pp_tx_valid", tx_valid, 1);
    chk("pp_tx_byte",  tx_byte,  8'hE1);
    drain(2000);

    // Random traffic well past one pointer wrap.
    wrote = 0;
    n = 0;
    while (wrote < 40 && n < 20000) begin
      if (m_q.size() < DEPTH && $urandom_range(0, 3) == 0) begin
        cycle(1'b1, 8'($urandom), 1'b0);
        wrote++;
      end else begin
        cycle(1'b0, 8'h00, 1'b0);
      end
      n++;
    end
    drain(5000);
    chk("wrap_empty", empty, 1);
    chk("wrap_count", count, 0);

    // Reset while the first of four queued bytes is on the wire.
    wait_xmit_idle(300);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC1 + 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("rst_count",    count,    0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_empty",    empty,    1);
    wait_xmit_idle(300);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("post_rst_valid", tx_valid, 1);
    chk("post_rst_byte",  tx_byte,  8'h3C);
    drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
